// File: rtl/dither_frame_packer.sv
// Frame-buffer readout packer: thresholds 8-bit pixels to 1 bit, packs 8 per byte MSB-first,
// and streams bytes over valid/ready. Define PACKER_HEADER_EN to prepend a 2-byte frame header.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_HDR   | queueing the two header bytes (PACKER_HEADER_EN only)
// S_FETCH | issuing buffer reads 0..IMAGE_SIZE-1 as FIFO credit allows
// S_DRAIN | waiting for the last pixel byte to be packed and handshaken
// S_FIN   | one-cycle done pulse
module dither_frame_packer #(
   parameter int IMAGEX     = 64,
   parameter int IMAGEY     = 64,
   parameter int IMAGE_SIZE = IMAGEX * IMAGEY,
   parameter int RGB_SIZE   = 8,
   parameter int THRESHOLD  = 128,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = $clog2(IMAGE_SIZE)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_rd_en,
   output logic [ADDR_W-1:0]   o_rd_addr,
   input  logic [RGB_SIZE-1:0] i_rd_data,
   output logic [7:0]          o_tx_data,
   output logic                o_tx_valid,
   input  logic                i_tx_ready,
   output logic                o_tx_last
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(IMAGE_SIZE - 1);
   localparam logic [CNT_W-1:0]    DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [RGB_SIZE-1:0] THRESH_C  = RGB_SIZE'(THRESHOLD);
`ifdef PACKER_HEADER_EN
   localparam logic [7:0] HDR_B1 = {4'($clog2(IMAGEX)), 4'($clog2(IMAGEY))};
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_FETCH,
      S_DRAIN,
      S_FIN
   } state_t;

   state_t r_state, w_state_nxt;

   logic [ADDR_W-1:0] r_rd_addr;
   logic              r_rd_vld;
   logic              r_rd_last;
   logic [6:0]        r_pack;
   logic [2:0]        r_bit_cnt;
`ifdef PACKER_HEADER_EN
   logic              r_hdr_idx;
`endif

   logic [8:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic       w_pending;
   logic       w_credit;
   logic       w_rd_en;
   logic       w_bit;
   logic [7:0] w_pack_nxt;
   logic       w_pix_push;
   logic       w_hdr_push;
   logic       w_push;
   logic       w_pop;
   logic [7:0] w_push_data;
   logic       w_push_last;
   logic       w_fifo_full;
   logic       w_tx_valid;
   logic       w_busy;
   logic       w_done;

   // A partly packed byte or a read in flight will claim one FIFO slot, so reserve it.
   assign w_pending   = r_rd_vld | (r_bit_cnt != 3'd0);
   assign w_credit    = (r_count + CNT_W'(w_pending)) < DEPTH_C;
   assign w_bit       = (i_rd_data >= THRESH_C);
   assign w_pack_nxt  = {r_pack, w_bit};
   assign w_pix_push  = r_rd_vld && (r_bit_cnt == 3'd7);
   assign w_push      = w_pix_push | w_hdr_push;
   assign w_fifo_full = (r_count == DEPTH_C);
   assign w_tx_valid  = (r_count != '0);
   assign w_pop       = w_tx_valid & i_tx_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      w_hdr_push  = 1'b0;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (i_start) begin
`ifdef PACKER_HEADER_EN
               w_state_nxt = S_HDR;
`else
               w_state_nxt = S_FETCH;
`endif
            end
         end
         S_HDR: begin
`ifdef PACKER_HEADER_EN
            if (!w_fifo_full) begin
               w_hdr_push = 1'b1;
               if (r_hdr_idx) begin
                  w_state_nxt = S_FETCH;
               end
            end
`else
            w_state_nxt = S_FETCH;
`endif
         end
         S_FETCH: begin
            w_rd_en = w_credit;
            if (w_credit && (r_rd_addr == LAST_ADDR)) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((r_count == '0) && !w_pending) begin
               w_state_nxt = S_FIN;
            end
         end
         S_FIN: begin
            w_busy      = 1'b0;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_push_data = w_pack_nxt;
      w_push_last = r_rd_last;
`ifdef PACKER_HEADER_EN
      if (w_hdr_push) begin
         w_push_data = r_hdr_idx ? HDR_B1 : 8'hA5;
         w_push_last = 1'b0;
      end
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_addr <= '0;
         r_rd_vld  <= 1'b0;
         r_rd_last <= 1'b0;
         r_pack    <= '0;
         r_bit_cnt <= '0;
      end else begin
         if (w_rd_en) begin
            r_rd_addr <= (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + ADDR_W'(1);
         end
         r_rd_vld  <= w_rd_en;
         r_rd_last <= w_rd_en && (r_rd_addr == LAST_ADDR);
         if (r_rd_vld) begin
            r_pack    <= w_pack_nxt[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
      end
   end

`ifdef PACKER_HEADER_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hdr_idx <= 1'b0;
      end else if (w_hdr_push) begin
         r_hdr_idx <= ~r_hdr_idx;
      end
   end
`endif

   // Each entry carries {last, data} so tx_last stays aligned with its byte.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {w_push_last, w_push_data};
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_busy     = w_busy;
   assign o_done     = w_done;
   assign o_rd_en    = w_rd_en;
   assign o_rd_addr  = r_rd_addr;
   assign o_tx_valid = w_tx_valid;
   assign o_tx_data  = r_mem[r_rd_ptr][7:0];
   assign o_tx_last  = w_tx_valid & r_mem[r_rd_ptr][8];

endmodule
